accel_avg: RTL and testbench

Downstream smoothing stage for the accelerometer SPI reader: takes each freshly read signed 8-bit X/Y/Z sample triple with a one-cycle strobe. Keeps a boxcar moving average over the last 2^LOG2_N triples. Publishes the averaged axes plus a hysteresis-filtered tilt classification for X and Y, for the display/LED logic.

---
 rtl/accel_avg_pkg.sv | 18 +
 rtl/accel_avg_if.sv | 13 +
 rtl/accel_avg_axis.sv | 34 +++
 rtl/accel_avg.sv | 71 +++++++
 tb/tb_accel_avg.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/accel_avg_pkg.sv
// accel_pkg: shared FSM/tilt types, default parameters and the tilt classifier
package accel_pkg;
    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_OUTPUT} state_t;
    typedef enum logic [1:0] {TILT_LEVEL = 2'b00, TILT_POS = 2'b01, TILT_NEG = 2'b10} tilt_t;
    localparam int DEF_LOG2_N  = 3;
    localparam int DEF_TILT_TH = 32;
    localparam int DEF_HYST    = 8;
    // Entry thresholds win over exit, so a swing past the far threshold flips sign directly
    function automatic tilt_t tilt_next(input tilt_t cur, input logic signed [7:0] avg,
                                        input int th, input int hy);
        int a;
        a = int'(avg);
        return (a > th)                        ? TILT_POS   :
               (a < -th)                       ? TILT_NEG   :
               (cur == TILT_POS && a < th - hy) ? TILT_LEVEL :
               (cur == TILT_NEG && a > hy - th) ? TILT_LEVEL : cur;
    endfunction
endpackage

// File: rtl/accel_avg_if.sv
// accel_avg_if: sample strobe/inputs from the SPI reader and averaged results out
interface accel_avg_if;
    logic              sample_tick;
    logic signed [7:0] x_in, y_in, z_in;
    logic signed [7:0] x_avg, y_avg, z_avg;
    logic              avg_valid;
    logic [1:0]        tilt_x, tilt_y;
    logic              busy, overrun;
    modport master (output sample_tick, x_in, y_in, z_in,
                    input  x_avg, y_avg, z_avg, avg_valid, tilt_x, tilt_y, busy, overrun);
    modport slave  (input  sample_tick, x_in, y_in, z_in,
                    output x_avg, y_avg, z_avg, avg_valid, tilt_x, tilt_y, busy, overrun);
endinterface

// File: rtl/accel_avg_axis.sv
// accel_avg_axis: one axis of the boxcar window - sample buffer, running sum, average
module accel_avg_axis import accel_pkg::*; #(
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_upd,
    input  logic                 i_pub,
    input  logic                 i_full,
    input  logic [LOG2_N-1:0]    i_ptr,
    input  logic signed [7:0]    i_in,
    output logic signed [7:0]    o_avg_next,
    output logic signed [7:0]    o_avg
);
    localparam int SW = 8 + LOG2_N;
    logic signed [7:0]    r_buf [2**LOG2_N];
    logic signed [SW-1:0] r_sum, w_in, w_old;
    logic signed [7:0]    r_avg;
    assign w_in       = SW'(i_in);
    assign w_old      = i_full ? SW'(r_buf[i_ptr]) : '0;
    assign o_avg_next = 8'(r_sum >>> LOG2_N);
    assign o_avg      = r_avg;
    // Stale entries are never read before being overwritten, so no reset
    always_ff @(posedge clk)
        if (i_upd) r_buf[i_ptr] <= i_in;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sum <= '0;
            r_avg <= '0;
        end else begin
            if (i_upd) r_sum <= r_sum + w_in - w_old;
            if (i_pub) r_avg <= o_avg_next;
        end
endmodule

// File: rtl/accel_avg.sv
// accel_avg: moving average over 2^LOG2_N accelerometer triples with hysteresis
// tilt classification of X and Y; one accepted sample per three cycles.
module accel_avg import accel_pkg::*; #(
    parameter int LOG2_N  = DEF_LOG2_N,
    parameter int TILT_TH = DEF_TILT_TH,
    parameter int HYST    = DEF_HYST
) (
    input  logic         clk,
    input  logic         reset,
    accel_avg_if.slave   bus
);
    localparam logic [LOG2_N:0] N = (LOG2_N + 1)'(1 << LOG2_N);
    state_t            r_state;
    logic [LOG2_N-1:0] r_ptr;
    logic [LOG2_N:0]   r_fill;
    logic signed [7:0] r_in [3];
    logic              r_valid, r_overrun;
    tilt_t             r_tilt_x, r_tilt_y;
    logic              w_full, w_upd, w_pub;
    logic signed [7:0] w_next [3];
    logic signed [7:0] w_avg [3];
    assign w_full = r_fill == N;
    assign w_upd  = r_state == S_UPDATE;
    assign w_pub  = r_state == S_OUTPUT && w_full;
    genvar a;
    for (a = 0; a < 3; a++) begin : g_axis
        accel_avg_axis #(.LOG2_N(LOG2_N)) u_axis (
            .clk(clk), .rst_n(reset), .i_upd(w_upd), .i_pub(w_pub), .i_full(w_full),
            .i_ptr(r_ptr), .i_in(r_in[a]), .o_avg_next(w_next[a]), .o_avg(w_avg[a]));
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_fill    <= '0;
            r_in      <= '{default: '0};
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_tilt_x  <= TILT_LEVEL;
            r_tilt_y  <= TILT_LEVEL;
        end else begin
            r_valid <= w_pub;
            if (bus.sample_tick && r_state != S_IDLE) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: if (bus.sample_tick) begin
                    r_in    <= '{bus.x_in, bus.y_in, bus.z_in};
                    r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_fill  <= w_full ? r_fill : r_fill + 1'b1;
                    r_state <= S_OUTPUT;
                end
                default: begin
                    if (w_pub) begin
                        r_tilt_x <= tilt_next(r_tilt_x, w_next[0], TILT_TH, HYST);
                        r_tilt_y <= tilt_next(r_tilt_y, w_next[1], TILT_TH, HYST);
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    assign bus.x_avg     = w_avg[0];
    assign bus.y_avg     = w_avg[1];
    assign bus.z_avg     = w_avg[2];
    assign bus.avg_valid = r_valid;
    assign bus.tilt_x    = r_tilt_x;
    assign bus.tilt_y    = r_tilt_y;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.overrun   = r_overrun;
endmodule

// File: tb/tb_accel_avg.sv
// tb_accel_avg: directed scenarios for accel_avg with hand-computed expectations
module tb_accel_avg;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    accel_avg_if bus();
    accel_avg dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Tick in cycle c; returns in cycle c+3 with avg_valid sampled there
    task automatic do_tick(input logic signed [7:0] x, y, z, output logic v);
        bus.sample_tick = 1'b1;
        bus.x_in = x;
        bus.y_in = y;
        bus.z_in = z;
        cyc();
        bus.sample_tick = 1'b0;
        cyc(2);
        v = bus.avg_valid;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset;
        bus.sample_tick = 1'b0;
        bus.x_in = '0;
        bus.y_in = '0;
        bus.z_in = '0;
        reset = 1'b0;
        cyc(2);
        n_cmp++; if ({bus.x_avg, bus.y_avg, bus.z_avg} !== 24'h0) begin n_err++; $display("FAIL reset_avg: got %h want 000000", {bus.x_avg, bus.y_avg, bus.z_avg}); end
        n_cmp++; if ({bus.avg_valid, bus.busy, bus.overrun} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {bus.avg_valid, bus.busy, bus.overrun}); end
        n_cmp++; if ({bus.tilt_x, bus.tilt_y} !== 4'b0000) begin n_err++; $display("FAIL reset_tilt: got %b want 0000", {bus.tilt_x, bus.tilt_y}); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_warmup;
        logic v;
        for (int i = 1; i <= 8; i++) begin
            do_tick(8'sd16, -8'sd16, 8'sd64, v);
            n_cmp++; if (v !== (i == 8)) begin n_err++; $display("FAIL warmup_valid tick %0d: got %b want %b", i, v, i == 8); end
            if (i < 8) cyc();
        end
        n_cmp++; if (bus.x_avg !== 8'sd16) begin n_err++; $display("FAIL warmup_x: got %0d want 16", bus.x_avg); end
        n_cmp++; if (bus.y_avg !== 8'hF0) begin n_err++; $display("FAIL warmup_y: got %h want f0", bus.y_avg); end
        n_cmp++; if (bus.z_avg !== 8'sd64) begin n_err++; $display("FAIL warmup_z: got %0d want 64", bus.z_avg); end
        n_cmp++; if ({bus.tilt_x, bus.tilt_y} !== 4'b0000) begin n_err++; $display("FAIL warmup_tilt: got %b want 0000", {bus.tilt_x, bus.tilt_y}); end
        cyc();
        n_cmp++; if (bus.avg_valid !== 1'b0) begin n_err++; $display("FAIL warmup_pulse: got %b want 0", bus.avg_valid); end
        n_cmp++; if (bus.x_avg !== 8'sd16) begin n_err++; $display("FAIL warmup_hold: got %0d want 16", bus.x_avg); end
    endtask

    task automatic test_hysteresis;
        logic v;
        for (int i = 0; i < 8; i++) begin do_tick(8'sd0, 8'sd0, 8'sd0, v); cyc(); end
        for (int k = 1; k <= 8; k++) begin
            do_tick(8'sd40, 8'sd0, 8'sd0, v);
            n_cmp++; if (bus.x_avg !== 8'(5 * k)) begin n_err++; $display("FAIL ramp_up_avg %0d: got %0d want %0d", k, bus.x_avg, 5 * k); end
            n_cmp++; if (bus.tilt_x !== ((k >= 7) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL ramp_up_tilt %0d: got %b want %b", k, bus.tilt_x, (k >= 7) ? 2'b01 : 2'b00); end
            cyc();
        end
        for (int j = 1; j <= 8; j++) begin
            do_tick(8'sd0, 8'sd0, 8'sd0, v);
            if (j <= 4) begin
                n_cmp++; if (bus.x_avg !== 8'(40 - 5 * j)) begin n_err++; $display("FAIL ramp_dn_avg %0d: got %0d want %0d", j, bus.x_avg, 40 - 5 * j); end
                n_cmp++; if (bus.tilt_x !== ((j <= 3) ? 2'b01 : 2'b00)) begin n_err++; $display("FAIL ramp_dn_tilt %0d: got %b want %b", j, bus.tilt_x, (j <= 3) ? 2'b01 : 2'b00); end
            end
            cyc();
        end
    endtask

    task automatic test_rounding;
        logic v;
        do_tick(-8'sd1, 8'sd0, 8'sd0, v);
        cyc();
        for (int i = 0; i < 7; i++) begin do_tick(8'sd0, 8'sd0, 8'sd0, v); cyc(); end
        n_cmp++; if (bus.x_avg !== 8'hFF) begin n_err++; $display("FAIL round_neg1: got %h want ff", bus.x_avg); end
        for (int i = 0; i < 8; i++) begin do_tick(-8'sd128, 8'sd0, 8'sd0, v); cyc(); end
        n_cmp++; if (bus.x_avg !== 8'h80) begin n_err++; $display("FAIL round_min: got %h want 80", bus.x_avg); end
        n_cmp++; if (bus.tilt_x !== 2'b10) begin n_err++; $display("FAIL round_min_tilt: got %b want 10", bus.tilt_x); end
        for (int k = 1; k <= 8; k++) begin
            do_tick(8'sd127, 8'sd0, 8'sd0, v);
            if (k == 3) begin
                n_cmp++; if (bus.x_avg !== -8'sd33) begin n_err++; $display("FAIL swing_k3_avg: got %0d want -33", bus.x_avg); end
                n_cmp++; if (bus.tilt_x !== 2'b10) begin n_err++; $display("FAIL swing_k3_tilt: got %b want 10", bus.tilt_x); end
            end
            if (k == 4) begin
                n_cmp++; if (bus.x_avg !== -8'sd1) begin n_err++; $display("FAIL swing_k4_avg: got %0d want -1", bus.x_avg); end
                n_cmp++; if (bus.tilt_x !== 2'b00) begin n_err++; $display("FAIL swing_k4_tilt: got %b want 00", bus.tilt_x); end
            end
            cyc();
        end
        n_cmp++; if (bus.x_avg !== 8'sd127) begin n_err++; $display("FAIL round_max: got %0d want 127", bus.x_avg); end
        n_cmp++; if (bus.tilt_x !== 2'b01) begin n_err++; $display("FAIL round_max_tilt: got %b want 01", bus.tilt_x); end
    endtask

    task automatic test_overrun;
        logic v;
        do_reset();
        bus.sample_tick = 1'b1;
        bus.x_in = 8'sd8;
        bus.y_in = 8'sd0;
        bus.z_in = 8'sd0;
        cyc();
        bus.x_in = 8'sd100;
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ovr_busy: got %b want 1", bus.busy); end
        cyc();
        bus.sample_tick = 1'b0;
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
        cyc(2);
        for (int i = 1; i <= 7; i++) begin
            do_tick(8'sd8, 8'sd0, 8'sd0, v);
            n_cmp++; if (v !== (i == 7)) begin n_err++; $display("FAIL ovr_valid tick %0d: got %b want %b", i, v, i == 7); end
            cyc();
        end
        n_cmp++; if (bus.x_avg !== 8'sd8) begin n_err++; $display("FAIL ovr_avg: got %0d want 8", bus.x_avg); end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    endtask

    task automatic test_reset_mid;
        logic v;
        bus.sample_tick = 1'b1;
        bus.x_in = 8'sd50;
        cyc();
        bus.sample_tick = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({bus.x_avg, bus.y_avg, bus.z_avg} !== 24'h0) begin n_err++; $display("FAIL mid_avg: got %h want 000000", {bus.x_avg, bus.y_avg, bus.z_avg}); end
        n_cmp++; if ({bus.avg_valid, bus.busy, bus.overrun, bus.tilt_x, bus.tilt_y} !== 7'b0) begin n_err++; $display("FAIL mid_flags: got %b want 0000000", {bus.avg_valid, bus.busy, bus.overrun, bus.tilt_x, bus.tilt_y}); end
        cyc(2);
        reset = 1'b1;
        cyc();
        for (int i = 1; i <= 8; i++) begin
            do_tick(8'sd24, 8'sd0, 8'sd0, v);
            n_cmp++; if (v !== (i == 8)) begin n_err++; $display("FAIL mid_valid tick %0d: got %b want %b", i, v, i == 8); end
            cyc();
        end
        n_cmp++; if (bus.x_avg !== 8'sd24) begin n_err++; $display("FAIL mid_result: got %0d want 24", bus.x_avg); end
    endtask

    task automatic test_back_to_back;
        logic v;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            do_tick(8'(i), 8'sd0, 8'sd0, v);
            n_cmp++; if (v !== (i >= 8)) begin n_err++; $display("FAIL b2b_valid tick %0d: got %b want %b", i, v, i >= 8); end
            if (i == 8) begin
                n_cmp++; if (bus.x_avg !== 8'sd4) begin n_err++; $display("FAIL b2b_first: got %0d want 4", bus.x_avg); end
            end
        end
        n_cmp++; if (bus.x_avg !== 8'sd12) begin n_err++; $display("FAIL b2b_last: got %0d want 12", bus.x_avg); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", bus.overrun); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_warmup();
        test_hysteresis();
        test_rounding();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
